load_scoreboard: RTL and testbench

- Parametrised pending-load scoreboard for the decode stage; successor to the single-bit reg_loading vector stall logic.
- Tracks outstanding loads per integer register with a counter, so a register may have several loads in flight. Previously only one was allowed.
- Accepts several clear channels per cycle (LSQ writeback, load cancel, and others).
- Evaluates stall for NRD source-read queries plus one destination check.
- Adds flush, optional same-cycle clear bypass and an underflow error flag.

---
 rtl/load_scoreboard_pkg.sv | 9 +
 rtl/load_scoreboard_sb_counter.sv | 47 ++++
 rtl/load_scoreboard.sv | 111 +++++++++++
 tb/tb_load_scoreboard.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/load_scoreboard_pkg.sv
// Shared register-file constants and address type for the pending-load scoreboard.
package load_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_XREG   = 32;

  typedef logic [REG_ADDR_W-1:0] xreg_addr_t;

endpackage

// File: rtl/load_scoreboard_sb_counter.sv
// Per-register saturating up/down counter of outstanding loads.
module sb_counter #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk_i,
  input  logic             resetb_i,
  input  logic             clk_en_i,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  // Two guard bits so the sign and the overflow are both visible.
  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((1 << CNT_W) - 1);

  logic signed [SUM_W-1:0] sum;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [SUM_W-1:0] s);
    if (s < 0)
      return '0;
    else if (s > MAX_S)
      return MAX_S[CNT_W-1:0];
    else
      return s[CNT_W-1:0];
  endfunction

  always_comb begin
    sum       = SUM_W'(count) + SUM_W'(inc) - SUM_W'(dec);
    underflow = !flush && (sum < 0);
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i)
      count <= '0;
    else if (clk_en_i) begin
      if (flush)
        count <= '0;
      else
        count <= sat_cnt(sum);
    end
  end

endmodule

// File: rtl/load_scoreboard.sv
// Decode-stage pending-load scoreboard: per-register load counters, multi-channel
// clears and combinational stall evaluation for source reads and the destination.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int NRD        = 2,
  parameter int NCLR       = 2,
  parameter int CNT_W      = 2,
  parameter int WAW_STRICT = 0,
  parameter int CLR_BYPASS = 1
) (
  input  logic                       clk_i,
  input  logic                       clk_en_i,
  input  logic                       resetb_i,
  input  logic [NRD-1:0]             rd_i,
  input  logic [REG_ADDR_W*NRD-1:0]  rd_addr_i,
  input  logic                       dst_chk_i,
  input  logic [REG_ADDR_W-1:0]      dst_addr_i,
  input  logic                       issue_i,
  input  logic [REG_ADDR_W-1:0]      issue_addr_i,
  input  logic [NCLR-1:0]            clr_i,
  input  logic [REG_ADDR_W*NCLR-1:0] clr_addr_i,
  input  logic                       flush_i,
  output logic                       stall_o,
  output logic                       busy_o,
  output logic                       err_underflow_o
);

  localparam int HIT_W = $clog2(NCLR + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [HIT_W-1:0] hits [NUM_XREG];
  logic [CNT_W-1:0] cnt  [NUM_XREG];
  logic [CNT_W-1:0] eff  [NUM_XREG];
  logic [NUM_XREG-1:0] uf;

  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] c,
                                               input logic [HIT_W-1:0] h);
    if ({{HIT_W{1'b0}}, c} < {{CNT_W{1'b0}}, h})
      return '0;
    else
      return c - CNT_W'(h);
  endfunction

  always_comb begin
    for (int r = 0; r < NUM_XREG; r++)
      hits[r] = '0;
    for (int r = 0; r < NUM_XREG; r++)
      for (int k = 0; k < NCLR; k++)
        if (clr_i[k] && clr_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))
          hits[r] = hits[r] + HIT_W'(1);
  end

  // x0 is hardwired: no counter, never pending.
  assign cnt[0] = '0;
  assign uf[0]  = 1'b0;

  for (genvar r = 1; r < NUM_XREG; r++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W),
      .DEC_W (HIT_W)
    ) u_cnt (
      .clk_i     (clk_i),
      .resetb_i  (resetb_i),
      .clk_en_i  (clk_en_i),
      .inc       (issue_i && (issue_addr_i == REG_ADDR_W'(r))),
      .dec       (hits[r]),
      .flush     (flush_i),
      .count     (cnt[r]),
      .underflow (uf[r])
    );
  end

  always_comb begin
    for (int r = 0; r < NUM_XREG; r++)
      eff[r] = (CLR_BYPASS != 0) ? sat_sub(cnt[r], hits[r]) : cnt[r];
  end

  always_comb begin
    xreg_addr_t a;
    stall_o = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr_i[k*REG_ADDR_W +: REG_ADDR_W];
      if (rd_i[k] && a != '0 && eff[a] != '0)
        stall_o = 1'b1;
    end
    if (dst_chk_i && dst_addr_i != '0) begin
      if (WAW_STRICT != 0) begin
        if (eff[dst_addr_i] != '0)
          stall_o = 1'b1;
      end else if (eff[dst_addr_i] == CNT_MAX)
        stall_o = 1'b1;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int r = 1; r < NUM_XREG; r++)
      if (cnt[r] != '0)
        busy_o = 1'b1;
  end

  // Underflow is reported one enabled cycle after the offending clear.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i)
      err_underflow_o <= 1'b0;
    else if (clk_en_i)
      err_underflow_o <= |uf;
  end

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard: three parameter variants share one stimulus.
module tb_load_scoreboard;

  logic        clk = 1'b0;
  logic        clk_en, resetb;
  logic [1:0]  rd;
  logic [9:0]  rd_addr;
  logic        dst_chk;
  logic [4:0]  dst_addr;
  logic        issue;
  logic [4:0]  issue_addr;
  logic [1:0]  clr;
  logic [9:0]  clr_addr;
  logic        flush;
  logic        stall, busy, err;
  logic        stall_nb, busy_nb, err_nb;
  logic        stall_ws, busy_ws, err_ws;

  int checks = 0;
  int errors = 0;
  int mcnt [32];

  always #5 clk = ~clk;

  load_scoreboard dut (
    .clk_i(clk), .clk_en_i(clk_en), .resetb_i(resetb), .rd_i(rd), .rd_addr_i(rd_addr),
    .dst_chk_i(dst_chk), .dst_addr_i(dst_addr), .issue_i(issue), .issue_addr_i(issue_addr),
    .clr_i(clr), .clr_addr_i(clr_addr), .flush_i(flush),
    .stall_o(stall), .busy_o(busy), .err_underflow_o(err));

  load_scoreboard #(.CLR_BYPASS(0)) dut_nb (
    .clk_i(clk), .clk_en_i(clk_en), .resetb_i(resetb), .rd_i(rd), .rd_addr_i(rd_addr),
    .dst_chk_i(dst_chk), .dst_addr_i(dst_addr), .issue_i(issue), .issue_addr_i(issue_addr),
    .clr_i(clr), .clr_addr_i(clr_addr), .flush_i(flush),
    .stall_o(stall_nb), .busy_o(busy_nb), .err_underflow_o(err_nb));

  load_scoreboard #(.WAW_STRICT(1)) dut_ws (
    .clk_i(clk), .clk_en_i(clk_en), .resetb_i(resetb), .rd_i(rd), .rd_addr_i(rd_addr),
    .dst_chk_i(dst_chk), .dst_addr_i(dst_addr), .issue_i(issue), .issue_addr_i(issue_addr),
    .clr_i(clr), .clr_addr_i(clr_addr), .flush_i(flush),
    .stall_o(stall_ws), .busy_o(busy_ws), .err_underflow_o(err_ws));

  typedef struct {
    bit       en;
    bit [1:0] rd;
    bit [4:0] ra0, ra1;
    bit       dchk;
    bit [4:0] da;
    bit       iss;
    bit [4:0] ia;
    bit [1:0] clr;
    bit [4:0] ca0, ca1;
    bit       fl;
    bit       s, s_nb, s_ws, busy, err;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit en, bit [1:0] rd_v, bit [4:0] ra0, bit [4:0] ra1,
                              bit dchk, bit [4:0] da, bit iss, bit [4:0] ia,
                              bit [1:0] clr_v, bit [4:0] ca0, bit [4:0] ca1, bit fl,
                              bit s, bit s_nb, bit s_ws, bit bz, bit er);
    vec_t v;
    v.en = en; v.rd = rd_v; v.ra0 = ra0; v.ra1 = ra1; v.dchk = dchk; v.da = da;
    v.iss = iss; v.ia = ia; v.clr = clr_v; v.ca0 = ca0; v.ca1 = ca1; v.fl = fl;
    v.s = s; v.s_nb = s_nb; v.s_ws = s_ws; v.busy = bz; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    clk_en = 1'b1; rd = '0; rd_addr = '0; dst_chk = 1'b0; dst_addr = '0;
    issue = 1'b0; issue_addr = '0; clr = '0; clr_addr = '0; flush = 1'b0;
  endtask

  task automatic model_step(input vec_t v);
    if (!v.en) return;
    if (v.fl) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      return;
    end
    if (v.iss && v.ia != 0) begin
      assert (mcnt[v.ia] < 3) else $error("vector issues to a saturated register %0d", v.ia);
      mcnt[v.ia]++;
    end
    if (v.clr[0] && v.ca0 != 0) mcnt[v.ca0]--;
    if (v.clr[1] && v.ca1 != 0) mcnt[v.ca1]--;
    for (int r = 0; r < 32; r++) if (mcnt[r] < 0) mcnt[r] = 0;
  endtask

  initial begin
    //          en rd    ra0 ra1 dchk da iss ia  clr   ca0 ca1 fl  s nb ws busy err
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 1, 5,  2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b01, 5,  0, 0, 0, 1, 5,  2'b00, 0,  0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2'b01, 5,  0, 0, 0, 0, 0,  2'b01, 5,  0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2'b01, 5,  0, 0, 0, 0, 0,  2'b01, 5,  0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 2'b01, 5,  0, 0, 0, 0, 0,  2'b00, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 1, 7,  2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 0, 0,  2'b11, 7,  7, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 0, 0,  2'b00, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 1, 3,  2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b01, 3,  0, 0, 0, 0, 0,  2'b01, 3,  0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 1, 9, 1, 9,  2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 1, 9, 1, 9,  2'b00, 0,  0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 1, 9, 1, 9,  2'b00, 0,  0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 1, 9, 0, 0,  2'b00, 0,  0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2'b10, 0,  9, 0, 0, 0, 0,  2'b00, 0,  0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 1, 6,  2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b01, 9,  0, 0, 0, 1, 4,  2'b11, 6,  6, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0,  0, 1, 0, 1, 0,  2'b01, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 1, 2,  2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'b01, 2,  0, 0, 0, 1, 2,  2'b11, 2,  2, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 2'b01, 2,  0, 0, 0, 0, 0,  2'b00, 0,  0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 0, 0,  2'b10, 0,  2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 1, 13, 2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b01, 13, 0, 0, 0, 1, 13, 2'b01, 13, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 2'b01, 13, 0, 0, 0, 0, 0,  2'b00, 0,  0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 0, 0,  2'b01, 13, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 1, 14, 2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,  0, 0, 0, 1, 14, 2'b00, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b01, 14, 0, 0, 0, 0, 0,  2'b11, 14, 14, 0, 0, 1, 0, 0, 0));

    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    idle();
    resetb = 1'b0;
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err, 1'b0);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      clk_en = vecs[i].en; rd = vecs[i].rd; rd_addr = {vecs[i].ra1, vecs[i].ra0};
      dst_chk = vecs[i].dchk; dst_addr = vecs[i].da;
      issue = vecs[i].iss; issue_addr = vecs[i].ia;
      clr = vecs[i].clr; clr_addr = {vecs[i].ca1, vecs[i].ca0}; flush = vecs[i].fl;
      model_step(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), stall, vecs[i].s);
      chk($sformatf("v%0d_stall_nobypass", i), stall_nb, vecs[i].s_nb);
      chk($sformatf("v%0d_stall_wawstrict", i), stall_ws, vecs[i].s_ws);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_busy_nobypass", i), busy_nb, vecs[i].busy);
    end

    // Underflow pulse must hold across a disabled cycle, then async reset mid-cycle.
    idle(); issue = 1'b1; issue_addr = 5'd11;
    @(posedge clk); #1;
    idle(); clr = 2'b11; clr_addr = {5'd11, 5'd11}; issue = 1'b1; issue_addr = 5'd12;
    @(posedge clk); #1;
    chk("seq_err_set", err, 1'b1);
    chk("seq_busy_set", busy, 1'b1);
    idle(); clk_en = 1'b0; issue = 1'b1; issue_addr = 5'd12;
    @(posedge clk); #1;
    chk("seq_err_hold_disabled", err, 1'b1);
    idle(); rd = 2'b01; rd_addr = {5'd0, 5'd12};
    #1;
    chk("seq_stall_pending", stall, 1'b1);
    #2;
    resetb = 1'b0;
    #1;
    chk("seq_reset_stall", stall, 1'b0);
    chk("seq_reset_busy", busy, 1'b0);
    chk("seq_reset_err", err, 1'b0);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk); #1;
    chk("seq_after_reset_stall", stall, 1'b0);
    chk("seq_after_reset_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
